// File: rtl/pic_fetch_unit.sv
// pic_fetch_unit: PIC10F200 instruction-fetch stage.
// Holds the program counter, the circular return stack and the instruction
// register, and steps them from the controller's PC, stack and IR strobes.
module pic_fetch_unit #(
    parameter int unsigned     PC_W        = 9,
    parameter int unsigned     IR_W        = 12,
    parameter int unsigned     STACK_DEPTH = 2,
    parameter logic [PC_W-1:0] RESET_VEC   = '0,
    localparam int unsigned    SP_W        = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              pc_inc,
    input  logic              pc_load,
    input  logic              pc_mux_sel,
    input  logic              ir_load,
    input  logic              stack_load,
    input  logic              stack_inc,
    input  logic              stack_dec,
    input  logic [IR_W-1:0]   rom_data,
    output logic [PC_W-1:0]   rom_addr,
    output logic [PC_W-1:0]   pc,
    output logic [IR_W-1:0]   ir_bus,
    output logic [PC_W-1:0]   stack_top,
    output logic [SP_W-1:0]   sp,
    output logic              stack_ovf,
    output logic              stack_unf
);

    localparam logic [2:0]      GOTO_OP = 3'b101;
    localparam logic [SP_W-1:0] SP_MAX  = SP_W'(STACK_DEPTH - 1);

    logic [PC_W-1:0] stack_mem [STACK_DEPTH];

    logic            is_goto;
    logic [PC_W-1:0] literal_pc;
    logic [PC_W-1:0] pc_next;
    logic [SP_W-1:0] sp_next;
    logic            ovf_next;
    logic            unf_next;

    // Combinational views: ROM is addressed straight from the PC, stack top is an async read
    assign rom_addr  = pc;
    assign stack_top = stack_mem[sp];

    // GOTO carries a 9-bit target; CALL only 8 bits, so its page bit is forced low
    always_comb begin
        is_goto    = (ir_bus[IR_W-1 -: 3] == GOTO_OP);
        literal_pc = is_goto ? PC_W'(ir_bus[8:0]) : PC_W'({1'b0, ir_bus[7:0]});
    end

    // Next PC: load beats increment beats hold; increment wraps silently
    always_comb begin
        pc_next = pc;
        if (pc_load) begin
            pc_next = pc_mux_sel ? literal_pc : stack_top;
        end else if (pc_inc) begin
            pc_next = pc + PC_W'(1);
        end
    end

    // Stack pointer steps modulo depth; wrapping either way latches a sticky flag
    always_comb begin
        sp_next  = sp;
        ovf_next = stack_ovf;
        unf_next = stack_unf;
        if (stack_inc && !stack_dec) begin
            sp_next = (sp == SP_MAX) ? '0 : sp + SP_W'(1);
            if (sp == SP_MAX) begin
                ovf_next = 1'b1;
            end
        end else if (stack_dec && !stack_inc) begin
            sp_next = (sp == '0) ? SP_MAX : sp - SP_W'(1);
            if (sp == '0) begin
                unf_next = 1'b1;
            end
        end
    end

    // PC, IR, stack pointer and flag registers
    always_ff @(posedge clk) begin
        if (rst) begin
            pc        <= RESET_VEC;
            ir_bus    <= '0;
            sp        <= '0;
            stack_ovf <= 1'b0;
            stack_unf <= 1'b0;
        end else begin
            pc        <= pc_next;
            sp        <= sp_next;
            stack_ovf <= ovf_next;
            stack_unf <= unf_next;
            if (ir_load) begin
                ir_bus <= rom_data;
            end
        end
    end

    // Return stack: writes the pre-edge PC into the pre-edge slot
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < int'(STACK_DEPTH); i++) begin
                stack_mem[i] <= '0;
            end
        end else if (stack_load) begin
            stack_mem[sp] <= pc;
        end
    end

endmodule

// File: tb/tb_pic_fetch_unit.sv
// tb_pic_fetch_unit: directed scoreboard bench for the fetch stage.
// Each cycle's strobes are paired with hand-derived expected outputs that are
// queued when driven and compared one cycle later.
module tb_pic_fetch_unit;

    localparam logic [7:0] RST  = 8'h80;
    localparam logic [7:0] INC  = 8'h40;
    localparam logic [7:0] LOAD = 8'h20;
    localparam logic [7:0] MUX  = 8'h10;
    localparam logic [7:0] IRL  = 8'h08;
    localparam logic [7:0] SLD  = 8'h04;
    localparam logic [7:0] SINC = 8'h02;
    localparam logic [7:0] SDEC = 8'h01;

    typedef struct {
        string       tag;
        logic [8:0]  pc;
        logic [11:0] ir;
        logic        sp;
        logic [8:0]  top;
        logic        ovf;
        logic        unf;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        pc_inc = 1'b0;
    logic        pc_load = 1'b0;
    logic        pc_mux_sel = 1'b0;
    logic        ir_load = 1'b0;
    logic        stack_load = 1'b0;
    logic        stack_inc = 1'b0;
    logic        stack_dec = 1'b0;
    logic [11:0] rom_data;
    logic [8:0]  rom_addr;
    logic [8:0]  pc;
    logic [11:0] ir_bus;
    logic [8:0]  stack_top;
    logic [0:0]  sp;
    logic        stack_ovf;
    logic        stack_unf;

    logic [11:0] rom [512];
    exp_t        sb [$];
    int          vectors = 0;
    int          miscompares = 0;

    assign rom_data = rom[rom_addr];

    always #5 clk = ~clk;

    pic_fetch_unit dut (
        .clk        (clk),
        .rst        (rst),
        .pc_inc     (pc_inc),
        .pc_load    (pc_load),
        .pc_mux_sel (pc_mux_sel),
        .ir_load    (ir_load),
        .stack_load (stack_load),
        .stack_inc  (stack_inc),
        .stack_dec  (stack_dec),
        .rom_data   (rom_data),
        .rom_addr   (rom_addr),
        .pc         (pc),
        .ir_bus     (ir_bus),
        .stack_top  (stack_top),
        .sp         (sp),
        .stack_ovf  (stack_ovf),
        .stack_unf  (stack_unf)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Drive one cycle of strobes, queue its expectation, compare after the edge
    task automatic tick(input logic [7:0] s, input string tag,
                        input logic [8:0] e_pc, input logic [11:0] e_ir, input logic e_sp,
                        input logic [8:0] e_top, input logic e_ovf, input logic e_unf);
        exp_t e;
        exp_t o;
        {rst, pc_inc, pc_load, pc_mux_sel, ir_load, stack_load, stack_inc, stack_dec} = s;
        e.tag = tag; e.pc = e_pc; e.ir = e_ir; e.sp = e_sp;
        e.top = e_top; e.ovf = e_ovf; e.unf = e_unf;
        sb.push_back(e);
        @(posedge clk);
        #1;
        {rst, pc_inc, pc_load, pc_mux_sel, ir_load, stack_load, stack_inc, stack_dec} = 8'h00;
        o = sb.pop_front();
        check({o.tag, ".pc"},   32'(pc),        32'(o.pc));
        check({o.tag, ".addr"}, 32'(rom_addr),  32'(o.pc));
        check({o.tag, ".ir"},   32'(ir_bus),    32'(o.ir));
        check({o.tag, ".sp"},   32'(sp),        32'(o.sp));
        check({o.tag, ".top"},  32'(stack_top), 32'(o.top));
        check({o.tag, ".ovf"},  32'(stack_ovf), 32'(o.ovf));
        check({o.tag, ".unf"},  32'(stack_unf), 32'(o.unf));
    endtask

    initial begin
        for (int i = 0; i < 512; i++) rom[i] = 12'h000;
        rom[9'h000] = 12'hC05;
        rom[9'h001] = 12'h000;
        rom[9'h002] = 12'hB7F;
        rom[9'h17F] = 12'h9F3;
        rom[9'h0F4] = 12'hBFF;
        rom[9'h1FF] = 12'hA12;
        rom[9'h012] = 12'h940;
        @(negedge clk);

        // Reset and normal fetch
        tick(RST,        "reset",    9'h000, 12'h000, 1'b0, 9'h000, 1'b0, 1'b0);
        tick(IRL | INC,  "fetch0",   9'h001, 12'hC05, 1'b0, 9'h000, 1'b0, 1'b0);
        tick(IRL | INC,  "fetch1",   9'h002, 12'h000, 1'b0, 9'h000, 1'b0, 1'b0);
        tick(IRL | INC,  "fetch2",   9'h003, 12'hB7F, 1'b0, 9'h000, 1'b0, 1'b0);
        // Literal loads
        tick(LOAD | MUX, "goto",     9'h17F, 12'hB7F, 1'b0, 9'h000, 1'b0, 1'b0);
        tick(IRL | INC,  "fetch3",   9'h180, 12'h9F3, 1'b0, 9'h000, 1'b0, 1'b0);
        tick(LOAD | MUX | INC, "call_lit", 9'h0F3, 12'h9F3, 1'b0, 9'h000, 1'b0, 1'b0);
        // Skip, then wrap through 1FF with a fetch on the same edge
        tick(INC,        "skip",     9'h0F4, 12'h9F3, 1'b0, 9'h000, 1'b0, 1'b0);
        tick(IRL | INC,  "fetch4",   9'h0F5, 12'hBFF, 1'b0, 9'h000, 1'b0, 1'b0);
        tick(LOAD | MUX, "goto_1ff", 9'h1FF, 12'hBFF, 1'b0, 9'h000, 1'b0, 1'b0);
        tick(IRL | INC,  "wrap",     9'h000, 12'hA12, 1'b0, 9'h000, 1'b0, 1'b0);
        tick(LOAD | MUX, "goto_012", 9'h012, 12'hA12, 1'b0, 9'h000, 1'b0, 1'b0);
        // CALL / RETLW round trip
        tick(IRL,        "ir_only",  9'h012, 12'h940, 1'b0, 9'h000, 1'b0, 1'b0);
        tick(SLD,        "call_a",   9'h012, 12'h940, 1'b0, 9'h012, 1'b0, 1'b0);
        tick(LOAD | MUX | SINC, "call_b", 9'h040, 12'h940, 1'b1, 9'h000, 1'b0, 1'b0);
        tick(SDEC,       "ret_a",    9'h040, 12'h940, 1'b0, 9'h012, 1'b0, 1'b0);
        tick(LOAD,       "ret_b",    9'h012, 12'h940, 1'b0, 9'h012, 1'b0, 1'b0);

        // Overflow: three pushes of 010, 020, 030
        tick(RST,        "reset2",   9'h000, 12'h000, 1'b0, 9'h000, 1'b0, 1'b0);
        rom[9'h000] = 12'hA10;
        rom[9'h010] = 12'hA20;
        rom[9'h020] = 12'hA30;
        tick(IRL,        "ld_a10",   9'h000, 12'hA10, 1'b0, 9'h000, 1'b0, 1'b0);
        tick(LOAD | MUX, "go_010",   9'h010, 12'hA10, 1'b0, 9'h000, 1'b0, 1'b0);
        tick(SLD | SINC, "push1",    9'h010, 12'hA10, 1'b1, 9'h000, 1'b0, 1'b0);
        tick(IRL,        "ld_a20",   9'h010, 12'hA20, 1'b1, 9'h000, 1'b0, 1'b0);
        tick(LOAD | MUX, "go_020",   9'h020, 12'hA20, 1'b1, 9'h000, 1'b0, 1'b0);
        tick(SLD | SINC, "push2",    9'h020, 12'hA20, 1'b0, 9'h010, 1'b1, 1'b0);
        tick(IRL,        "ld_a30",   9'h020, 12'hA30, 1'b0, 9'h010, 1'b1, 1'b0);
        tick(LOAD | MUX, "go_030",   9'h030, 12'hA30, 1'b0, 9'h010, 1'b1, 1'b0);
        tick(SLD | SINC, "push3",    9'h030, 12'hA30, 1'b1, 9'h020, 1'b1, 1'b0);
        tick(LOAD | SDEC, "pop_same", 9'h020, 12'hA30, 1'b0, 9'h030, 1'b1, 1'b0);
        tick(SDEC,       "underflow", 9'h020, 12'hA30, 1'b1, 9'h020, 1'b1, 1'b1);
        tick(SINC | SDEC, "inc_dec", 9'h020, 12'hA30, 1'b1, 9'h020, 1'b1, 1'b1);
        tick(8'h00,      "sticky",   9'h020, 12'hA30, 1'b1, 9'h020, 1'b1, 1'b1);

        // Underflow straight from reset
        tick(RST,        "reset3",   9'h000, 12'h000, 1'b0, 9'h000, 1'b0, 1'b0);
        tick(SDEC,       "unf_rst",  9'h000, 12'h000, 1'b1, 9'h000, 1'b0, 1'b1);

        // Reset in the middle of a CALL
        tick(RST,        "reset4",   9'h000, 12'h000, 1'b0, 9'h000, 1'b0, 1'b0);
        rom[9'h000] = 12'hA55;
        tick(IRL,        "ld_a55",   9'h000, 12'hA55, 1'b0, 9'h000, 1'b0, 1'b0);
        tick(LOAD | MUX, "go_055",   9'h055, 12'hA55, 1'b0, 9'h000, 1'b0, 1'b0);
        tick(SLD,        "mid_a",    9'h055, 12'hA55, 1'b0, 9'h055, 1'b0, 1'b0);
        tick(RST | LOAD | MUX | SINC, "rst_mid", 9'h000, 12'h000, 1'b0, 9'h000, 1'b0, 1'b0);
        tick(SINC,       "slot1_clr", 9'h000, 12'h000, 1'b1, 9'h000, 1'b0, 1'b0);
        tick(SDEC,       "slot0_clr", 9'h000, 12'h000, 1'b0, 9'h000, 1'b0, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/pic_fetch_unit.md
# pic_fetch_unit

Instruction-fetch stage of the PIC10F200 core. Holds the 9-bit program counter, the two-level return stack and the 12-bit instruction register. Sits directly downstream of the core controller: it consumes the controller's PC, stack and IR strobes, addresses the program ROM, and returns `ir_bus` to the controller and datapath.

## Interface
- `PC_W`, 9, program counter / ROM address width
- `IR_W`, 12, instruction width
- `STACK_DEPTH`, 2, return stack entries (power of 2)
- `RESET_VEC`, 9'h000, PC value after reset
- `clk`  in  1  core instruction clock, all state updates on rising edge
- `rst`  in  1  reset, synchronous, active-high
- `pc_inc`  in  1  PC <= PC+1
- `pc_load`  in  1  PC <= source selected by `pc_mux_sel`
- `pc_mux_sel`  in  1  0: stack top, 1: literal from IR
- `ir_load`  in  1  IR <= `rom_data`
- `stack_load`  in  1  stack[sp] <= PC
- `stack_inc`  in  1  sp <= sp+1
- `stack_dec`  in  1  sp <= sp-1
- `rom_data`  in  IR_W  program ROM word at `rom_addr`, combinational read
- `rom_addr`  out  PC_W  equals `pc`
- `pc`  out  PC_W  current program counter
- `ir_bus`  out  IR_W  instruction register
- `stack_top`  out  PC_W  stack[sp], combinational
- `sp`  out  log2(STACK_DEPTH)  stack pointer
- `stack_ovf`  out  1  sticky overflow flag
- `stack_unf`  out  1  sticky underflow flag

## Operation
- Reset (takes priority over every strobe): pc=RESET_VEC, ir_bus=0, sp=0, all stack entries=0, stack_ovf=0, stack_unf=0.
- PC update priority: pc_load > pc_inc > hold.
- Literal source (pc_mux_sel=1): if ir_bus[11:9]==3'b101 (GOTO), load ir_bus[8:0]; otherwise (CALL) load {1'b0, ir_bus[7:0]}.
- Stack source (pc_mux_sel=0): load `stack_top` as sampled before the edge.
- pc_inc wraps 9'h1FF -> 9'h000; no flag is raised.
- The stack is a circular register file indexed by sp. stack_load writes the pre-edge PC into stack[pre-edge sp].
- sp arithmetic is modulo STACK_DEPTH:
  - stack_inc with sp==STACK_DEPTH-1 wraps sp to 0 and sets stack_ovf.
  - stack_dec with sp==0 wraps sp to STACK_DEPTH-1 and sets stack_unf.
  - Both flags clear only on reset.
- stack_inc and stack_dec together: sp and both flags unchanged.
- CALL sequence from the controller: cycle A stack_load (PC already points to the return address); cycle B pc_load (mux=1) + stack_inc.
- RETLW sequence: cycle A stack_dec; cycle B pc_load (mux=0).
- ir_load captures rom_data addressed by the pre-edge PC. ir_load + pc_inc in the same cycle is the normal fetch: IR gets ROM[PC], PC advances.
- Skip instructions (DECFSZ/INCFSZ) are pc_inc without ir_load; IR holds.

## Timing
- All registers update on the clk rising edge. Outputs are registered except `stack_top` and `rom_addr` (=pc).
- PC-to-IR latency: 1 cycle (rom_addr valid after the edge, IR captured at the next edge with ir_load).
- Load, increment and stack effects are visible on outputs the cycle after the strobe.
- Same-edge read/write is allowed: pc_load (mux=0) + stack_dec loads the old stack[sp]. stack_load + stack_inc writes the old slot, then advances.
- A reset asserted mid-CALL or mid-RETLW discards the partial sequence. No strobe has effect in a reset cycle.

## Test plan
- Reset/fetch: rst 1 cycle, ROM[0]=12'hC05, ROM[1]=12'h000; pulse ir_load+pc_inc twice -> ir_bus=12'hC05 then 12'h000, pc=0,1,2. After reset, ir_bus=0 and all flags 0.
- GOTO/CALL literal:
  - ir_bus=12'hB7F, pc_load mux=1 -> pc=9'h17F.
  - ir_bus=12'h9F3 -> pc=9'h0F3 (bit 8 forced 0).
  - pc_load+pc_inc together -> load wins.
- CALL/RETLW round trip: pc=9'h012; stack_load, then pc_load+stack_inc with ir_bus=12'h940 -> pc=9'h040, sp=1, stack[0]=9'h012. Then stack_dec, then pc_load mux=0 -> pc=9'h012, sp=0.
- Stack overflow/underflow:
  - Three pushes (PC 9'h010, 9'h020, 9'h030) -> sp wraps to 1, stack_ovf=1, stack[0]=9'h030.
  - From reset, stack_dec -> sp=1, stack_unf=1.
  - Flags stay set until rst.
- Wrap and skip: pc=9'h1FF, pc_inc -> pc=0. Skip: pc_inc without ir_load -> pc advances, ir_bus unchanged.
- Reset mid-sequence: after a CALL cycle A, assert rst with pc_load+stack_inc active -> pc=RESET_VEC, sp=0, stack cleared.
